uart_tx_arbiter: RTL and testbench

// Round-robin, packet-locking arbiter that shares one uart_tx byte channel among NUM_CH requesters.

---
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_tx byte channel among NUM_CH requesters.
// Optional idle-timeout release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PKT    = 16,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_CH-1:0]            req_last,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic                         tx_ready,
    output logic                         tx_valid,
    output logic [DATA_WIDTH-1:0]        tx_data,
    output logic                         grant_valid,
    output logic [$clog2(NUM_CH)-1:0]    grant_id,
    output logic                         pkt_done,
    output logic                         timeout_evt
);

    localparam int CH_W     = $clog2(NUM_CH);
    localparam int CNT_W    = $clog2(MAX_PKT + 1);
    localparam int GAP_W    = $clog2(GAP_CYCLES + 2);
    localparam int GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   scan_idx;
    logic              found;
    logic [CNT_W-1:0]  byte_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              valid_g;
    logic              last_g;
    logic              xfer;
    logic              release_now;
    logic              timeout_now;

    // Rotating priority: start the search just after the last released channel.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_idx = CH_W'((int'(last_grant) + i) % NUM_CH);
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && scan_idx == CH_W'(j) && req_valid[j]) begin
                    found  = 1'b1;
                    winner = scan_idx;
                end
            end
        end
    end

    always_comb begin
        valid_g   = 1'b0;
        last_g    = 1'b0;
        tx_data   = req_data[DATA_WIDTH-1:0];
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == CH_W'(i)) begin
                valid_g      = req_valid[i];
                last_g       = req_last[i];
                tx_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = (state == LOCK) && tx_ready;
            end
        end
    end

    assign grant_valid = (state == LOCK);
    assign xfer        = (state == LOCK) && valid_g && tx_ready;
    assign tx_valid    = xfer;
    assign release_now = (xfer && (last_g || byte_cnt == CNT_W'(MAX_PKT - 1))) || timeout_now;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] idle_cnt;
    logic            timeout_q;

    assign timeout_now = (state == LOCK) && !valid_g && (idle_cnt == TO_W'(TIMEOUT - 1));
    assign timeout_evt = timeout_q;

    // Counts consecutive starved LOCK cycles of the granted channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_now;
            if (state != LOCK || xfer || release_now) begin
                idle_cnt <= '0;
            end else if (!valid_g) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_now = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (found) state_next = LOCK;
            LOCK: if (release_now) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gap_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, packet length and gap bookkeeping; pkt_done trails the release by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= CH_W'(NUM_CH - 1);
            grant_id   <= '0;
            byte_cnt   <= '0;
            gap_cnt    <= '0;
            pkt_done   <= 1'b0;
        end else begin
            state    <= state_next;
            pkt_done <= release_now;
            case (state)
                IDLE: begin
                    if (found) grant_id <= winner;
                end
                LOCK: begin
                    if (release_now) begin
                        last_grant <= grant_id;
                        byte_cnt   <= '0;
                        gap_cnt    <= GAP_W'(GAP_INIT);
                    end else if (xfer) begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with default parameters.
// Timeout scenario follows UART_ARB_TIMEOUT_EN the same way the design does.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        pkt_done;
    logic        timeout_evt;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pkt_done    (pkt_done),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    // Inputs change at edge+1, outputs are sampled at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int c, input logic [7:0] d);
        req_data[c*8 +: 8] = d;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        tick();
        compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_grant_valid got %b want 0", grant_valid); end
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_grant_id got %0d want 0", grant_id); end
        compared++; if (pkt_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_pkt_done got %b want 0", pkt_done); end
        compared++; if (timeout_evt !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_timeout_evt got %b want 0", timeout_evt); end
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_req_ready got %b want 0000", req_ready); end
        compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_tx_valid got %b want 0", tx_valid); end
        rst = 1'b0;
        tick();
        settle();
        compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_no_req got %b want 0", grant_valid); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        req_valid = 4'b0100;
        set_ch(2, 8'h22);
        tick();
        tick();
        settle();
        compared++; if (grant_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_locked got %b want 1", grant_valid); end
        compared++; if (grant_id !== 2'd2) begin mismatched++; $display("[TB] FAIL midrst_grant got %0d want 2", grant_id); end
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL midrst_stalled_ready got %b want 0000", req_ready); end
        tx_ready = 1'b1;
        settle();
        compared++; if (req_ready !== 4'b0100) begin mismatched++; $display("[TB] FAIL midrst_ready got %b want 0100", req_ready); end
        rst = 1'b1;
        #1;
        compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_abort got %b want 0", grant_valid); end
        compared++; if (req_ready !== 4'b0000) begin mismatched++; $display("[TB] FAIL midrst_abort_ready got %b want 0000", req_ready); end
        compared++; if (pkt_done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_pulse got %b want 0", pkt_done); end
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        tick();
        settle();
        compared++; if (grant_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_regrant got %b want 1", grant_valid); end
        compared++; if (grant_id !== 2'd0) begin mismatched++; $display("[TB] FAIL midrst_ch0_first got %0d want 0", grant_id); end
    endtask

    task automatic test_round_robin();
        int n        = 0;
        int last_cyc = -1;
        int done_at  = -1;
        do_reset();
        tx_ready  = 1'b1;
        req_last  = 4'b1111;
        for (int c = 0; c < 4; c++) set_ch(c, 8'(8'hA0 + c));
        req_valid = 4'b1111;
        settle();
        compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_arb_latency got %b want 0", tx_valid); end
        for (int cyc = 1; cyc < 120 && n < 5; cyc++) begin
            tick();
            settle();
            if (cyc == done_at) begin
                compared++; if (pkt_done !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_pkt_done got %b want 1", pkt_done); end
                compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_gap_entry got %b want 0", grant_valid); end
            end
            if (tx_valid === 1'b1) begin
                compared++; if (grant_id !== 2'(n % 4)) begin mismatched++; $display("[TB] FAIL rr_order got %0d want %0d", grant_id, n % 4); end
                compared++; if (tx_data !== 8'(8'hA0 + n % 4)) begin mismatched++; $display("[TB] FAIL rr_data got %h want %h", tx_data, 8'(8'hA0 + n % 4)); end
                if (n == 0) begin
                    compared++; if (cyc !== 1) begin mismatched++; $display("[TB] FAIL rr_first_xfer_cycle got %0d want 1", cyc); end
                end else begin
                    compared++; if (cyc - last_cyc !== 18) begin mismatched++; $display("[TB] FAIL rr_spacing got %0d want 18", cyc - last_cyc); end
                end
                last_cyc = cyc;
                done_at  = cyc + 1;
                n++;
            end
        end
        compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL rr_count got %0d want 5", n); end
    endtask

    task automatic test_max_pkt();
        int k        = 0;
        int xfers    = 0;
        int done_at  = -1;
        bit started  = 1'b0;
        bit served0  = 1'b0;
        bit served3  = 1'b0;
        do_reset();
        tx_ready = 1'b1;
        req_last = 4'b1001;
        set_ch(0, 8'hC0);
        set_ch(3, 8'hC3);
        for (int cyc = 0; cyc < 200 && k < 20; cyc++) begin
            req_valid[2] = (k < 20);
            set_ch(2, 8'(k));
            req_valid[0] = started && !served0;
            req_valid[3] = started && !served3;
            settle();
            if (cyc == done_at) begin
                compared++; if (pkt_done !== 1'b1) begin mismatched++; $display("[TB] FAIL cap_pkt_done got %b want 1", pkt_done); end
            end
            if (tx_valid === 1'b1) begin
                xfers++;
                started = 1'b1;
                if (xfers == 17) begin
                    compared++; if (k !== 16) begin mismatched++; $display("[TB] FAIL cap_len got %0d want 16", k); end
                    compared++; if (grant_id !== 2'd3) begin mismatched++; $display("[TB] FAIL cap_next_grant got %0d want 3", grant_id); end
                end
                if (xfers == 18) begin
                    compared++; if (grant_id !== 2'd0) begin mismatched++; $display("[TB] FAIL cap_third_grant got %0d want 0", grant_id); end
                end
                if (xfers == 19) begin
                    compared++; if (grant_id !== 2'd2) begin mismatched++; $display("[TB] FAIL cap_regrant got %0d want 2", grant_id); end
                end
                if (grant_id == 2'd2) begin
                    compared++; if (tx_data !== 8'(k)) begin mismatched++; $display("[TB] FAIL cap_byte_order got %h want %h", tx_data, 8'(k)); end
                    k++;
                    if (k == 16) done_at = cyc + 1;
                end else if (grant_id == 2'd0) begin
                    served0 = 1'b1;
                end else if (grant_id == 2'd3) begin
                    served3 = 1'b1;
                end
            end
            tick();
        end
        compared++; if (k !== 20) begin mismatched++; $display("[TB] FAIL cap_complete got %0d want 20", k); end
    endtask

    task automatic test_tx_ready_toggle();
        int k       = 0;
        int done_at = -1;
        bit seen    = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            tx_ready     = (cyc % 2 == 1);
            req_valid    = (k < 6) ? 4'b0010 : 4'b0000;
            req_last[1]  = (k == 5);
            set_ch(1, 8'(8'h50 + k));
            settle();
            if (!tx_ready && k < 6) begin
                compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL tog_valid_no_ready got %b want 0", tx_valid); end
                if (k > 0) begin
                    compared++; if (grant_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL tog_grant_held got %b want 1", grant_valid); end
                end
            end
            if (tx_valid === 1'b1) begin
                compared++; if (tx_data !== 8'(8'h50 + k)) begin mismatched++; $display("[TB] FAIL tog_byte got %h want %h", tx_data, 8'(8'h50 + k)); end
                compared++; if (grant_id !== 2'd1) begin mismatched++; $display("[TB] FAIL tog_grant got %0d want 1", grant_id); end
                k++;
                if (k == 6) done_at = cyc + 1;
            end
            if (cyc == done_at) begin
                compared++; if (pkt_done !== 1'b1) begin mismatched++; $display("[TB] FAIL tog_pkt_done got %b want 1", pkt_done); end
                seen = 1'b1;
            end
            tick();
        end
        compared++; if (k !== 6) begin mismatched++; $display("[TB] FAIL tog_count got %0d want 6", k); end
    endtask

    task automatic test_timeout();
        int k      = 0;
        int last_x = -1;
        int pulses = 0;
        int tos    = 0;
        do_reset();
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = (k < 2) ? 4'b1000 : 4'b0000;
            set_ch(3, 8'(8'h30 + k));
            settle();
            if (tx_valid === 1'b1) begin
                compared++; if (tx_data !== 8'(8'h30 + k)) begin mismatched++; $display("[TB] FAIL to_byte got %h want %h", tx_data, 8'(8'h30 + k)); end
                k++;
                if (k == 2) last_x = cyc;
            end
            if (pkt_done === 1'b1) pulses++;
            if (timeout_evt === 1'b1) tos++;
`ifdef UART_ARB_TIMEOUT_EN
            if (last_x >= 0 && cyc == last_x + 256) begin
                compared++; if (grant_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL to_held_until_limit got %b want 1", grant_valid); end
            end
            if (last_x >= 0 && cyc == last_x + 257) begin
                compared++; if (pkt_done !== 1'b1) begin mismatched++; $display("[TB] FAIL to_pkt_done got %b want 1", pkt_done); end
                compared++; if (timeout_evt !== 1'b1) begin mismatched++; $display("[TB] FAIL to_evt got %b want 1", timeout_evt); end
                compared++; if (grant_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL to_released got %b want 0", grant_valid); end
            end
            if (last_x >= 0 && cyc == last_x + 258) begin
                compared++; if (timeout_evt !== 1'b0) begin mismatched++; $display("[TB] FAIL to_evt_width got %b want 0", timeout_evt); end
            end
`endif
            tick();
        end
        compared++; if (k !== 2) begin mismatched++; $display("[TB] FAIL to_bytes got %0d want 2", k); end
`ifdef UART_ARB_TIMEOUT_EN
        compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL to_pulse_count got %0d want 1", pulses); end
        compared++; if (tos !== 1) begin mismatched++; $display("[TB] FAIL to_evt_count got %0d want 1", tos); end
`else
        compared++; if (pulses !== 0) begin mismatched++; $display("[TB] FAIL noto_pulse_count got %0d want 0", pulses); end
        compared++; if (tos !== 0) begin mismatched++; $display("[TB] FAIL noto_evt_count got %0d want 0", tos); end
        compared++; if (grant_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL noto_grant_held got %b want 1", grant_valid); end
        compared++; if (grant_id !== 2'd3) begin mismatched++; $display("[TB] FAIL noto_grant_id got %0d want 3", grant_id); end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_lock();
        test_round_robin();
        test_max_pkt();
        test_tx_ready_toggle();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
